// File: rtl/microwave_ctrl.sv
// Microwave oven sequencer: keypad digit entry into an external BCD countdown
// timer, cook/pause/done control of the magnetron, and door interlocking.
module microwave_ctrl #(
  parameter int MAX_DIGITS = 3,
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clr,
  input  logic       door_closed,
  input  logic       tick,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_clrn,
  output logic       timer_en,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(DONE_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_digit_cnt;
  logic [TW-1:0]   r_done_ticks;
  logic [3:0]      r_timer_data;
  logic            r_timer_loadn;
  logic            r_timer_clrn;
  logic            r_mag_on;
  logic            r_done;

  state_t          w_next;
  logic            w_load;
  logic            w_clear;
  logic            w_key_ok;
  logic            w_can_start;

  assign w_key_ok    = key_valid && (key_digit <= 4'd9) && (r_digit_cnt < CW'(MAX_DIGITS));
  assign w_can_start = start && door_closed && !timer_zero;

  // Next-state decision; each branch is ordered stop > door > zero > start > key.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      S_IDLE, S_ENTRY: begin
        if (stop_clr) begin
          w_next  = S_IDLE;
          w_clear = 1'b1;
        end else if (start) begin
          if ((r_state == S_ENTRY) && w_can_start)
            w_next = S_COOK;
        end else if (w_key_ok) begin
          w_load = 1'b1;
          w_next = S_ENTRY;
        end
      end
      S_COOK: begin
        if (stop_clr || !door_closed)
          w_next = S_PAUSE;
        else if (timer_zero)
          w_next = S_DONE;
      end
      S_PAUSE: begin
        if (stop_clr) begin
          w_next  = S_IDLE;
          w_clear = 1'b1;
        end else if (w_can_start) begin
          w_next = S_COOK;
        end
      end
      S_DONE: begin
        if (stop_clr || !door_closed)
          w_next = S_IDLE;
        else if (tick && (r_done_ticks == TW'(DONE_TICKS - 1)))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state       <= S_IDLE;
      r_digit_cnt   <= '0;
      r_done_ticks  <= '0;
      r_timer_data  <= '0;
      r_timer_loadn <= 1'b1;
      r_timer_clrn  <= 1'b0;
      r_mag_on      <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_mag_on      <= (w_next == S_COOK);
      r_done        <= (w_next == S_DONE);
      r_timer_clrn  <= !w_clear;
      // A clear always suppresses a coincident load strobe.
      r_timer_loadn <= !(w_load && !w_clear);
      if (w_load && !w_clear) begin
        r_timer_data <= key_digit;
        r_digit_cnt  <= r_digit_cnt + CW'(1);
      end
      if (w_next == S_IDLE)
        r_digit_cnt <= '0;
      if ((r_state == S_DONE) && (w_next == S_DONE) && tick)
        r_done_ticks <= r_done_ticks + TW'(1);
      else if (w_next != S_DONE)
        r_done_ticks <= '0;
    end
  end

  // Gated with the live door input so a tick racing a door opening is lost.
  assign timer_en    = tick && door_closed && (r_state == S_COOK);
  assign timer_data  = r_timer_data;
  assign timer_loadn = r_timer_loadn;
  assign timer_clrn  = r_timer_clrn;
  assign mag_on      = r_mag_on;
  assign done        = r_done;
  assign state       = r_state;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: directed scenarios followed by random
// traffic, all compared against a rule-level model of the oven controller.
module tb_microwave_ctrl;

  localparam int MAXD = 3;
  localparam int DTICKS = 3;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clk;
  logic       clr;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop_clr;
  logic       door_closed;
  logic       tick;
  logic       timer_zero;
  logic [3:0] timer_data;
  logic       timer_loadn;
  logic       timer_clrn;
  logic       timer_en;
  logic       mag_on;
  logic       done;
  logic [2:0] state;

  int testCount = 0;
  int failCount = 0;
  int loadPulses = 0;
  int enPulses = 0;
  int clrnLows = 0;
  logic doorLvl = 1'b1;
  logic tzLvl = 1'b1;

  int         mState = M_IDLE;
  int         mCnt = 0;
  int         mTicks = 0;
  logic [3:0] mData = 4'd0;
  logic       mLoadn = 1'b1;
  logic       mClrn = 1'b0;

  microwave_ctrl #(.MAX_DIGITS(MAXD), .DONE_TICKS(DTICKS)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clr(stop_clr), .door_closed(door_closed), .tick(tick),
    .timer_zero(timer_zero), .timer_data(timer_data), .timer_loadn(timer_loadn),
    .timer_clrn(timer_clrn), .timer_en(timer_en), .mag_on(mag_on), .done(done),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural oven: what the keypad, buttons and door should make happen this edge.
  task automatic modelStep(input logic iKv, input logic [3:0] iKd, input logic iStart,
                           input logic iStop, input logic iDoor, input logic iTick,
                           input logic iTz, input logic iClr);
    int nState, nCnt, nTicks;
    logic [3:0] nData;
    logic nLoadn, nClrn;
    bit editing;
    nState = mState; nCnt = mCnt; nTicks = mTicks; nData = mData;
    nLoadn = 1'b1; nClrn = 1'b1;
    editing = (mState == M_IDLE) || (mState == M_ENTRY);
    if (iClr) begin
      nState = M_IDLE; nCnt = 0; nTicks = 0; nData = 4'd0; nClrn = 1'b0;
    end else if (editing && iStop) begin
      nState = M_IDLE; nClrn = 1'b0;
    end else if (editing && iStart) begin
      if (mState == M_ENTRY && iDoor && !iTz) nState = M_COOK;
    end else if (editing) begin
      if (iKv && iKd <= 4'd9 && mCnt < MAXD) begin
        nData = iKd; nLoadn = 1'b0; nCnt = mCnt + 1; nState = M_ENTRY;
      end
    end else if (mState == M_COOK) begin
      if (iStop || !iDoor) nState = M_PAUSE;
      else if (iTz) nState = M_DONE;
    end else if (mState == M_PAUSE) begin
      if (iStop) begin nState = M_IDLE; nClrn = 1'b0; end
      else if (iStart && iDoor && !iTz) nState = M_COOK;
    end else begin
      if (iStop || !iDoor) nState = M_IDLE;
      else if (iTick) begin
        nTicks = mTicks + 1;
        if (nTicks >= DTICKS) nState = M_IDLE;
      end
    end
    if (nState == M_IDLE) nCnt = 0;
    if (nState != M_DONE) nTicks = 0;
    mState = nState; mCnt = nCnt; mTicks = nTicks; mData = nData;
    mLoadn = nLoadn; mClrn = nClrn;
  endtask

  task automatic applyStimulus(input logic iKv, input logic [3:0] iKd, input logic iStart,
                               input logic iStop, input logic iDoor, input logic iTick,
                               input logic iTz, input logic iClr);
    logic expEn;
    @(negedge clk);
    key_valid = iKv; key_digit = iKd; start = iStart; stop_clr = iStop;
    door_closed = iDoor; tick = iTick; timer_zero = iTz; clr = iClr;
    #1;
    expEn = iTick && iDoor && (mState == M_COOK);
    checkOutput("timer_en", {7'd0, timer_en}, {7'd0, expEn});
    if (timer_en === 1'b1) enPulses++;
    modelStep(iKv, iKd, iStart, iStop, iDoor, iTick, iTz, iClr);
    @(posedge clk);
    #1;
    checkOutput("state", {5'd0, state}, 8'(mState));
    checkOutput("mag_on", {7'd0, mag_on}, {7'd0, mState == M_COOK});
    checkOutput("done", {7'd0, done}, {7'd0, mState == M_DONE});
    checkOutput("timer_loadn", {7'd0, timer_loadn}, {7'd0, mLoadn});
    checkOutput("timer_clrn", {7'd0, timer_clrn}, {7'd0, mClrn});
    checkOutput("timer_data", {4'd0, timer_data}, {4'd0, mData});
    if (timer_loadn === 1'b0) loadPulses++;
    if (timer_clrn === 1'b0) clrnLows++;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, doorLvl, 1'b0, tzLvl, 1'b0);
  endtask

  task automatic pressKey(input logic [3:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, doorLvl, 1'b0, tzLvl, 1'b0);
    idleCycle();
  endtask

  task automatic pressStart();
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, doorLvl, 1'b0, tzLvl, 1'b0);
    idleCycle();
  endtask

  task automatic pressStop();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, doorLvl, 1'b0, tzLvl, 1'b0);
    idleCycle();
  endtask

  task automatic tickPulse();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, doorLvl, 1'b1, tzLvl, 1'b0);
    idleCycle();
  endtask

  initial begin
    clr = 1'b1; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop_clr = 1'b0;
    door_closed = 1'b1; tick = 1'b0; timer_zero = 1'b1;

    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("reset_clrn", {7'd0, timer_clrn}, 8'd0);
    idleCycle();
    checkOutput("release_clrn", {7'd0, timer_clrn}, 8'd1);

    // Three digits load, a fourth is refused.
    loadPulses = 0;
    pressKey(4'd1); pressKey(4'd3); pressKey(4'd0);
    checkOutput("entry_pulses", 8'(loadPulses), 8'd3);
    checkOutput("entry_state", {5'd0, state}, 8'd1);
    pressKey(4'd5);
    checkOutput("fourth_key", 8'(loadPulses), 8'd3);
    pressStop();

    // Full cook of 0:05 through DONE and auto-return.
    tzLvl = 1'b0;
    pressKey(4'd0); pressKey(4'd0); pressKey(4'd5);
    pressStart();
    checkOutput("cook_mag", {7'd0, mag_on}, 8'd1);
    enPulses = 0;
    for (int i = 0; i < 5; i++) tickPulse();
    checkOutput("cook_en_pulses", 8'(enPulses), 8'd5);
    tzLvl = 1'b1;
    idleCycle();
    checkOutput("done_flag", {7'd0, done}, 8'd1);
    checkOutput("done_mag", {7'd0, mag_on}, 8'd0);
    for (int i = 0; i < DTICKS; i++) tickPulse();
    checkOutput("done_return", {5'd0, state}, 8'd0);

    // Door opens on a tick mid-cook, then resume.
    tzLvl = 1'b0;
    pressKey(4'd1); pressKey(4'd0);
    pressStart();
    enPulses = 0;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("door_tick_en", 8'(enPulses), 8'd0);
    checkOutput("door_pause", {5'd0, state}, 8'd3);
    checkOutput("door_mag", {7'd0, mag_on}, 8'd0);
    pressStart();
    checkOutput("resume", {5'd0, state}, 8'd2);

    // Stop from PAUSE clears the timer once, and entry restarts at digit 1.
    pressStop();
    clrnLows = 0;
    pressStop();
    idleCycle();
    checkOutput("pause_clr_cycles", 8'(clrnLows), 8'd1);
    loadPulses = 0;
    pressKey(4'd7); pressKey(4'd8); pressKey(4'd9); pressKey(4'd1);
    checkOutput("fresh_entry", 8'(loadPulses), 8'd3);
    pressStop();

    // Illegal digit and start against an empty timer.
    loadPulses = 0;
    pressKey(4'hA);
    checkOutput("bad_digit", 8'(loadPulses), 8'd0);
    tzLvl = 1'b1;
    pressStart();
    checkOutput("start_zero_idle", {5'd0, state}, 8'd0);
    pressKey(4'd2);
    pressStart();
    checkOutput("start_zero_entry", {5'd0, state}, 8'd1);

    // Reset while cooking.
    tzLvl = 1'b0;
    pressStop();
    pressKey(4'd9);
    pressStart();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_state", {5'd0, state}, 8'd0);
    checkOutput("clr_mag", {7'd0, mag_on}, 8'd0);
    checkOutput("clr_clrn", {7'd0, timer_clrn}, 8'd0);
    idleCycle();
    checkOutput("clr_release", {7'd0, timer_clrn}, 8'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(2) == 0), 4'($urandom_range(15)),
                    ($urandom_range(5) == 0), ($urandom_range(15) == 0),
                    ($urandom_range(7) != 0), ($urandom_range(3) == 0),
                    ($urandom_range(9) == 0), ($urandom_range(63) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
